// File: rtl/cp0_pkg.sv
// Shared constants for coprocessor 0: exception codes, register numbers and
// helpers that assemble the architecturally visible SR and Cause words.
package cp0_pkg;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;
    // Code 31 is reserved as "no exception travelling down the pipe".
    localparam logic [4:0] EXC_NONE    = 5'd31;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;

    function automatic logic [31:0] packSr(input logic [5:0] im,
                                           input logic       exl,
                                           input logic       ie);
        return {16'b0, im, 8'b0, exl, ie};
    endfunction

    function automatic logic [31:0] packCause(input logic       bd,
                                              input logic [5:0] ip,
                                              input logic [4:0] excCode);
        return {bd, 15'b0, ip, 3'b0, excCode, 2'b0};
    endfunction

endpackage

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC registers, interrupt/exception request logic
// and the mtc0/mfc0 access port for the pipelined MIPS core.
module cp0
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    output logic [31:0] CP0Out,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic        Req
);

    logic [5:0]  imQ, imD;
    logic        exlQ, exlD;
    logic        ieQ, ieD;
    logic        bdQ, bdD;
    logic [5:0]  ipQ, ipD;
    logic [4:0]  excCodeQ, excCodeD;
    logic [31:0] epcQ, epcD;
    logic        intReq;
    logic        excReq;

    assign intReq = (|(HWInt & imQ)) & ieQ & ~exlQ;
    assign excReq = (ExcCodeIn != EXC_NONE) & ~exlQ;
    assign Req    = (intReq | excReq) & reset;

    // A taken exception overrides both eret and any mtc0 on the same edge.
    always_comb begin
        imD      = imQ;
        exlD     = exlQ;
        ieD      = ieQ;
        bdD      = bdQ;
        ipD      = HWInt;
        excCodeD = excCodeQ;
        epcD     = epcQ;
        if (Req) begin
            exlD     = 1'b1;
            bdD      = BDIn;
            excCodeD = intReq ? EXC_INT : ExcCodeIn;
            epcD     = BDIn ? (VPC - 32'd4) : VPC;
        end else begin
            if (EXLClr) begin
                exlD = 1'b0;
            end
            if (en) begin
                case (CP0Add)
                    REG_SR: begin
                        imD  = CP0In[15:10];
                        ieD  = CP0In[0];
                        exlD = CP0In[1] & ~EXLClr;
                    end
                    REG_EPC: epcD = CP0In;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imQ      <= 6'd0;
            exlQ     <= 1'b0;
            ieQ      <= 1'b0;
            bdQ      <= 1'b0;
            ipQ      <= 6'd0;
            excCodeQ <= 5'd0;
            epcQ     <= 32'd0;
        end else begin
            imQ      <= imD;
            exlQ     <= exlD;
            ieQ      <= ieD;
            bdQ      <= bdD;
            ipQ      <= ipD;
            excCodeQ <= excCodeD;
            epcQ     <= epcD;
        end
    end

    always_comb begin
        case (CP0Add)
            REG_SR:    CP0Out = packSr(imQ, exlQ, ieQ);
            REG_CAUSE: CP0Out = packCause(bdQ, ipQ, excCodeQ);
            REG_EPC:   CP0Out = epcQ;
            default:   CP0Out = 32'd0;
        endcase
    end

    assign EPCOut = epcQ;

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed scenarios followed by randomized
// traffic compared against a word-level reference model of the registers.
module tb_cp0;
    import cp0_pkg::*;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  CP0Add;
    logic [31:0] CP0In;
    logic [31:0] CP0Out;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] EPCOut;
    logic        Req;

    int testsRun;
    int testsFailed;

    logic [31:0] mSr;
    logic [31:0] mCause;
    logic [31:0] mEpc;

    cp0 dut (
        .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add), .CP0In(CP0In),
        .CP0Out(CP0Out), .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn),
        .HWInt(HWInt), .EXLClr(EXLClr), .EPCOut(EPCOut), .Req(Req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic modelIntPending();
        return ((HWInt & mSr[15:10]) != 6'd0) && mSr[0] && !mSr[1];
    endfunction

    function automatic logic modelReq();
        if (!reset) return 1'b0;
        return modelIntPending() || ((ExcCodeIn != EXC_NONE) && !mSr[1]);
    endfunction

    function automatic logic [31:0] modelRead(input logic [4:0] a);
        if (a == 5'd12) return mSr;
        if (a == 5'd13) return mCause;
        if (a == 5'd14) return mEpc;
        return 32'd0;
    endfunction

    task automatic modelZero();
        mSr = 32'd0; mCause = 32'd0; mEpc = 32'd0;
    endtask

    // Compute the architectural effect of the coming edge, then take it.
    task automatic tick();
        logic [31:0] nSr, nCause, nEpc;
        nSr = mSr; nCause = mCause; nEpc = mEpc;
        nCause[15:10] = HWInt;
        if (modelReq()) begin
            nSr[1] = 1'b1;
            nCause[31] = BDIn;
            nCause[6:2] = modelIntPending() ? 5'd0 : ExcCodeIn;
            nEpc = BDIn ? VPC - 32'd4 : VPC;
        end else begin
            if (EXLClr) nSr[1] = 1'b0;
            if (en && CP0Add == 5'd12) begin
                nSr = CP0In & 32'h0000_FC03;
                if (EXLClr) nSr[1] = 1'b0;
            end
            if (en && CP0Add == 5'd14) nEpc = CP0In;
        end
        @(posedge clk);
        if (reset) begin
            mSr = nSr; mCause = nCause; mEpc = nEpc;
        end else begin
            modelZero();
        end
        #1;
    endtask

    task automatic readReg(input logic [4:0] a);
        CP0Add = a;
        #1;
    endtask

    task automatic test_reset();
        ExcCodeIn = EXC_OV;
        for (int r = 12; r <= 14; r++) begin
            readReg(5'(r));
            testsRun++;
            if (CP0Out !== 32'd0) begin
                testsFailed++;
                $display("[TB] FAIL reset_read_r%0d: got %h expected %h", r, CP0Out, 32'd0);
            end
        end
        testsRun++;
        if (Req !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_req_low: got %b expected %b", Req, 1'b0);
        end
        @(posedge clk);
        #1;
        readReg(REG_SR);
        testsRun++;
        if (CP0Out !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_hold_sr: got %h expected %h", CP0Out, 32'd0);
        end
        reset = 1'b1;
        #1;
        testsRun++;
        if (Req !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_release_req: got %b expected %b", Req, 1'b1);
        end
        reset = 1'b0;
        #1;
        testsRun++;
        if (Req !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_same_cycle_req: got %b expected %b", Req, 1'b0);
        end
        @(posedge clk);
        #1;
        readReg(REG_EPC);
        testsRun++;
        if (EPCOut !== 32'd0 || CP0Out !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_same_cycle_epc: got %h expected %h", EPCOut, 32'd0);
        end
        reset = 1'b1;
        ExcCodeIn = EXC_NONE;
        modelZero();
    endtask

    task automatic test_exception();
        ExcCodeIn = EXC_OV; VPC = 32'h0000_3010; BDIn = 1'b0; HWInt = 6'd0;
        #1;
        testsRun++;
        if (Req !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL exc_req: got %b expected %b", Req, 1'b1);
        end
        tick();
        testsRun++;
        if (Req !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL exc_no_nest: got %b expected %b", Req, 1'b0);
        end
        ExcCodeIn = EXC_NONE;
        testsRun++;
        if (EPCOut !== 32'h0000_3010) begin
            testsFailed++;
            $display("[TB] FAIL exc_epc: got %h expected %h", EPCOut, 32'h0000_3010);
        end
        readReg(REG_CAUSE);
        testsRun++;
        if (CP0Out !== 32'h0000_0030) begin
            testsFailed++;
            $display("[TB] FAIL exc_cause: got %h expected %h", CP0Out, 32'h0000_0030);
        end
        readReg(REG_SR);
        testsRun++;
        if (CP0Out !== 32'h0000_0002) begin
            testsFailed++;
            $display("[TB] FAIL exc_sr: got %h expected %h", CP0Out, 32'h0000_0002);
        end
    endtask

    task automatic test_delay_slot();
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        ExcCodeIn = EXC_RI; VPC = 32'h0000_3024; BDIn = 1'b1;
        tick();
        ExcCodeIn = EXC_NONE; BDIn = 1'b0;
        testsRun++;
        if (EPCOut !== 32'h0000_3020) begin
            testsFailed++;
            $display("[TB] FAIL bd_epc: got %h expected %h", EPCOut, 32'h0000_3020);
        end
        readReg(REG_CAUSE);
        testsRun++;
        if (CP0Out !== 32'h8000_0028) begin
            testsFailed++;
            $display("[TB] FAIL bd_cause: got %h expected %h", CP0Out, 32'h8000_0028);
        end
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        ExcCodeIn = EXC_ADEL; VPC = 32'h0000_0000; BDIn = 1'b1;
        tick();
        ExcCodeIn = EXC_NONE; BDIn = 1'b0;
        testsRun++;
        if (EPCOut !== 32'hFFFF_FFFC) begin
            testsFailed++;
            $display("[TB] FAIL bd_epc_wrap: got %h expected %h", EPCOut, 32'hFFFF_FFFC);
        end
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
    endtask

    task automatic test_int_priority();
        en = 1'b1; CP0Add = REG_SR; CP0In = 32'h0000_0401;
        tick();
        en = 1'b0;
        readReg(REG_SR);
        testsRun++;
        if (CP0Out !== 32'h0000_0401) begin
            testsFailed++;
            $display("[TB] FAIL int_mtc0_sr: got %h expected %h", CP0Out, 32'h0000_0401);
        end
        HWInt = 6'b000001; ExcCodeIn = EXC_SYSCALL; VPC = 32'h0000_3100; BDIn = 1'b0;
        #1;
        testsRun++;
        if (Req !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL int_req: got %b expected %b", Req, 1'b1);
        end
        tick();
        ExcCodeIn = EXC_NONE;
        readReg(REG_CAUSE);
        testsRun++;
        if (CP0Out !== 32'h0000_0400) begin
            testsFailed++;
            $display("[TB] FAIL int_cause: got %h expected %h", CP0Out, 32'h0000_0400);
        end
        readReg(REG_SR);
        testsRun++;
        if (CP0Out !== 32'h0000_0403) begin
            testsFailed++;
            $display("[TB] FAIL int_sr_exl: got %h expected %h", CP0Out, 32'h0000_0403);
        end
    endtask

    task automatic test_masking();
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        HWInt = 6'b000010;
        #1;
        testsRun++;
        if (Req !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mask_req: got %b expected %b", Req, 1'b0);
        end
        tick();
        readReg(REG_CAUSE);
        testsRun++;
        if (CP0Out !== 32'h0000_0800) begin
            testsFailed++;
            $display("[TB] FAIL mask_cause_ip: got %h expected %h", CP0Out, 32'h0000_0800);
        end
    endtask

    task automatic test_eret_conflicts();
        HWInt = 6'b000001;
        tick();
        EXLClr = 1'b1;
        #1;
        testsRun++;
        if (Req !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL eret_req_in_exl: got %b expected %b", Req, 1'b0);
        end
        tick();
        EXLClr = 1'b0;
        readReg(REG_SR);
        testsRun++;
        if (CP0Out !== 32'h0000_0401 || Req !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL eret_clear: got sr=%h req=%b expected sr=%h req=1", CP0Out, Req, 32'h0000_0401);
        end
        en = 1'b1; CP0Add = REG_EPC; CP0In = 32'hDEAD_BEEF; VPC = 32'h0000_5000; EXLClr = 1'b1;
        tick();
        en = 1'b0; EXLClr = 1'b0;
        testsRun++;
        if (EPCOut !== 32'h0000_5000) begin
            testsFailed++;
            $display("[TB] FAIL conflict_epc: got %h expected %h", EPCOut, 32'h0000_5000);
        end
        readReg(REG_SR);
        testsRun++;
        if (CP0Out !== 32'h0000_0403) begin
            testsFailed++;
            $display("[TB] FAIL conflict_exl_wins: got %h expected %h", CP0Out, 32'h0000_0403);
        end
        HWInt = 6'd0;
        en = 1'b1; CP0Add = REG_SR; CP0In = 32'hFFFF_FC03; EXLClr = 1'b1;
        tick();
        en = 1'b0; EXLClr = 1'b0;
        readReg(REG_SR);
        testsRun++;
        if (CP0Out !== 32'h0000_FC01) begin
            testsFailed++;
            $display("[TB] FAIL eret_mtc0_sr: got %h expected %h", CP0Out, 32'h0000_FC01);
        end
        en = 1'b1; CP0Add = REG_CAUSE; CP0In = 32'hFFFF_FFFF;
        tick();
        CP0Add = 5'd5;
        tick();
        CP0Add = REG_EPC; CP0In = 32'h1234_5678;
        tick();
        en = 1'b0;
        readReg(REG_CAUSE);
        testsRun++;
        if (CP0Out !== 32'h0000_0000) begin
            testsFailed++;
            $display("[TB] FAIL cause_readonly: got %h expected %h", CP0Out, 32'h0000_0000);
        end
        readReg(5'd5);
        testsRun++;
        if (CP0Out !== 32'h0000_0000) begin
            testsFailed++;
            $display("[TB] FAIL other_reg_zero: got %h expected %h", CP0Out, 32'h0000_0000);
        end
        testsRun++;
        if (EPCOut !== 32'h1234_5678) begin
            testsFailed++;
            $display("[TB] FAIL mtc0_epc: got %h expected %h", EPCOut, 32'h1234_5678);
        end
    endtask

    task automatic test_async_reset();
        reset = 1'b0;
        ExcCodeIn = EXC_OV;
        #1;
        testsRun++;
        if (Req !== 1'b0 || EPCOut !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset_now: got req=%b epc=%h expected req=0 epc=0", Req, EPCOut);
        end
        readReg(REG_SR);
        testsRun++;
        if (CP0Out !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset_sr: got %h expected %h", CP0Out, 32'd0);
        end
        reset = 1'b1;
        ExcCodeIn = EXC_NONE;
        modelZero();
    endtask

    task automatic test_random();
        logic [4:0] codes [6];
        codes[0] = EXC_ADEL; codes[1] = EXC_ADES; codes[2] = EXC_SYSCALL;
        codes[3] = EXC_RI;   codes[4] = EXC_OV;   codes[5] = EXC_INT;
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: CP0Add = 5'd12;
                1: CP0Add = 5'd13;
                2: CP0Add = 5'd14;
                default: CP0Add = 5'($urandom);
            endcase
            CP0In     = $urandom;
            VPC       = $urandom & 32'hFFFF_FFFC;
            BDIn      = 1'($urandom_range(0, 1));
            ExcCodeIn = ($urandom_range(0, 3) == 0) ? codes[$urandom_range(0, 5)] : EXC_NONE;
            HWInt     = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
            EXLClr    = ($urandom_range(0, 3) == 0);
            #1;
            testsRun++;
            if (Req !== modelReq() || CP0Out !== modelRead(CP0Add) || EPCOut !== mEpc) begin
                testsFailed++;
                $display("[TB] FAIL rand_%0d: got req=%b out=%h epc=%h expected req=%b out=%h epc=%h",
                         i, Req, CP0Out, EPCOut, modelReq(), modelRead(CP0Add), mEpc);
            end
            if (i % 97 == 96) begin
                reset = 1'b0;
                modelZero();
                #1;
                testsRun++;
                if (Req !== 1'b0 || CP0Out !== 32'd0) begin
                    testsFailed++;
                    $display("[TB] FAIL rand_reset_%0d: got req=%b out=%h expected req=0 out=0", i, Req, CP0Out);
                end
                reset = 1'b1;
            end
            tick();
        end
        en = 1'b0; EXLClr = 1'b0; ExcCodeIn = EXC_NONE;
    endtask

    initial begin
        testsRun = 0;
        testsFailed = 0;
        reset = 1'b0;
        en = 1'b0;
        CP0Add = 5'd0;
        CP0In = 32'd0;
        VPC = 32'd0;
        BDIn = 1'b0;
        ExcCodeIn = EXC_NONE;
        HWInt = 6'd0;
        EXLClr = 1'b0;
        modelZero();
        #2;
        test_reset();
        test_exception();
        test_delay_slot();
        test_int_priority();
        test_masking();
        test_eret_conflicts();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
